// File: rtl/seq_detector.sv
// ---------------------------------------------------------------------------
// seq_detector
//
// Serial bit-pattern detector. A Mealy FSM tracks how many leading bits of
// PATTERN have been matched so far (0..PAT_LEN-1). The detect flag z is
// combinational: it is high while the current x completes the pattern, so
// downstream logic samples it on the same rising edge that consumes x.
//
// The transition table uses the KMP prefix-function fallback. It is built at
// elaboration time from PATTERN by a constant function.
//
// Parameters:
//   PAT_LEN  pattern length in bits (2..16)
//   PATTERN  pattern; PATTERN[PAT_LEN-1] is received first, PATTERN[0] last
//   OVERLAP  1: a match's suffix may seed the next match; 0: restart empty
//
// Ports:
//   clk  in   clock, all state updates on the rising edge
//   rst  in   synchronous active-high reset; also forces z low
//   x    in   serial data bit
//   z    out  detect flag (Mealy, combinational from state and x)
// ---------------------------------------------------------------------------
module seq_detector #(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b0110,
    parameter bit                 OVERLAP = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic x,
    output logic z
);

    localparam int SW = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1;

    typedef logic [SW-1:0] state_t;

    localparam state_t      LAST  = SW'(PAT_LEN - 1);
    localparam logic [31:0] PAT32 = 32'(PATTERN);

    // Next match length after seeing bit b with k bits already matched.
    // The candidate sequence is the matched prefix followed by b. The result
    // is the longest suffix of it that is also a prefix of the pattern. The
    // length is capped at PAT_LEN-1, which gives the proper-suffix rule on a
    // completed match.
    function automatic int kmp_next(input int k, input logic b);
        logic [31:0] seq;
        logic        ok;
        int          maxl;
        int          best;
        seq  = 32'd0;
        best = 0;
        for (int j = 0; j < k; j++) begin
            seq[5'(j)] = PAT32[5'(PAT_LEN - 1 - j)];
        end
        seq[5'(k)] = b;
        maxl = (k + 1 < PAT_LEN) ? (k + 1) : (PAT_LEN - 1);
        for (int l = 1; l <= maxl; l++) begin
            ok = 1'b1;
            for (int j = 0; j < l; j++) begin
                ok = ok & (seq[5'(k + 1 - l + j)] == PAT32[5'(PAT_LEN - 1 - j)]);
            end
            best = ok ? l : best;
        end
        if ((k == PAT_LEN - 1) && (b == PAT32[0]) && !OVERLAP) begin
            best = 0;
        end else begin
            best = best;
        end
        return best;
    endfunction

    // Pack the next-state column for input bit b: entry k sits at [k*SW +: SW].
    function automatic logic [PAT_LEN*SW-1:0] build_table(input logic b);
        logic [PAT_LEN*SW-1:0] tbl;
        tbl = '0;
        for (int k = PAT_LEN - 1; k >= 0; k--) begin
            tbl = (tbl << SW) | (PAT_LEN*SW)'(kmp_next(k, b));
        end
        return tbl;
    endfunction

    localparam logic [PAT_LEN*SW-1:0] NEXT0 = build_table(1'b0);
    localparam logic [PAT_LEN*SW-1:0] NEXT1 = build_table(1'b1);

    state_t state_r;
    state_t next_s;

    // State register: synchronous reset to "nothing matched".
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= '0;
        end else begin
            state_r <= next_s;
        end
    end

    // Next-state lookup. The default of zero also returns any unused
    // encoding (PAT_LEN not a power of two) to the empty state.
    always_comb begin
        next_s = '0;
        for (int k = 0; k < PAT_LEN; k++) begin
            next_s = (state_r == SW'(k))
                   ? (x ? SW'(NEXT1 >> (k * SW)) : SW'(NEXT0 >> (k * SW)))
                   : next_s;
        end
    end

    // Mealy detect flag: final pattern bit present while PAT_LEN-1 matched.
    always_comb begin
        z = 1'b0;
        if (!rst && (state_r == LAST) && (x == PATTERN[0])) begin
            z = 1'b1;
        end else begin
            z = 1'b0;
        end
    end

endmodule

// File: tb/tb_seq_detector.sv
// ---------------------------------------------------------------------------
// tb_seq_detector
//
// Directed, table-driven bench for seq_detector. It uses two instances:
//   dut  : default parameters (pattern 0110, overlapping matches)
//   dut2 : same pattern with OVERLAP=0
// Each table row is one clock cycle. The row's inputs are driven after a
// falling edge, z is checked 1 time unit later, and the next rising edge
// consumes the inputs. Hand-written sequences cover the mid-cycle Mealy
// change and the non-overlapping instance.
// ---------------------------------------------------------------------------
module tb_seq_detector;

    logic clk;
    logic rst;
    logic x;
    logic z;
    logic rst2;
    logic x2;
    logic z2;

    int n_vec;
    int n_fail;

    typedef struct {
        logic rst;
        logic x;
        logic z_exp;
    } vec_t;

    vec_t vecs[$];

    seq_detector dut (
        .clk (clk),
        .rst (rst),
        .x   (x),
        .z   (z)
    );

    seq_detector #(
        .PAT_LEN (4),
        .PATTERN (4'b0110),
        .OVERLAP (1'b0)
    ) dut2 (
        .clk (clk),
        .rst (rst2),
        .x   (x2),
        .z   (z2)
    );

    // 10-unit clock period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void add(input logic r, input logic xv, input logic ze);
        vec_t v;
        v.rst   = r;
        v.x     = xv;
        v.z_exp = ze;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: z=%b expected %b at t=%0t", name, act, exp, $time);
        end
    endtask

    initial begin
        n_vec  = 0;
        n_fail = 0;
        rst    = 1'b1;
        x      = 1'b0;
        rst2   = 1'b1;
        x2     = 1'b0;

        // Reset held for two edges with x toggling; z is forced low.
        add(1'b1, 1'b0, 1'b0);
        add(1'b1, 1'b1, 1'b0);
        // Release reset and feed 1,1,1: the state stays at S0.
        add(1'b0, 1'b1, 1'b0);
        add(1'b0, 1'b1, 1'b0);
        add(1'b0, 1'b1, 1'b0);
        // Overlapping stream 0,0,1,1,0,1,1,0,0,1,1,0 gives hits on bits 5, 8 and 12.
        add(1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b0);
        add(1'b0, 1'b1, 1'b0);
        add(1'b0, 1'b0, 1'b1);
        add(1'b0, 1'b1, 1'b0);
        add(1'b0, 1'b1, 1'b0);
        add(1'b0, 1'b0, 1'b1);
        add(1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b0);
        add(1'b0, 1'b1, 1'b0);
        add(1'b0, 1'b0, 1'b1);     // now at S1
        // From S1, x=1 reaches S2; then x=0 falls back to S1; then 1,1,0 hits.
        add(1'b0, 1'b1, 1'b0);
        add(1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b0);
        add(1'b0, 1'b1, 1'b0);
        add(1'b0, 1'b0, 1'b1);     // now at S1
        // From S1, 1,1 reaches S3; then x=1 falls back to S0; then 0,1,1,0 hits.
        add(1'b0, 1'b1, 1'b0);
        add(1'b0, 1'b1, 1'b0);
        add(1'b0, 1'b1, 1'b0);
        add(1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b0);
        add(1'b0, 1'b1, 1'b0);
        add(1'b0, 1'b0, 1'b1);     // now at S1
        // Reset mid-operation: 0,1,1 reaches S3. rst with x=0 would otherwise hit.
        add(1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b0);
        add(1'b0, 1'b1, 1'b0);
        add(1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b0);
        add(1'b0, 1'b0, 1'b0);     // now at S1

        // Apply the table: the first row starts before the first rising edge.
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst = vecs[i].rst;
            x   = vecs[i].x;
            #1;
            check($sformatf("vec%0d", i), z, vecs[i].z_exp);
        end

        // Mealy timing: drive to S3 from S1 with 1,1.
        @(negedge clk); rst = 1'b0; x = 1'b1; #1; check("mealy_pre1", z, 1'b0);
        @(negedge clk); x = 1'b1; #1; check("mealy_pre2", z, 1'b0);
        // In S3: x=1 keeps z low, then x=0 mid-cycle raises z before any edge.
        @(negedge clk); x = 1'b1; #1; check("mealy_s3_x1", z, 1'b0);
        #1 x = 1'b0; #1; check("mealy_s3_rise", z, 1'b1);
        // The edge consumes the 0 and moves to S1; the following 1 drops z.
        @(posedge clk); #1 x = 1'b1; #1; check("mealy_fall", z, 1'b0);

        // Non-overlapping instance: 0,1,1,0,1,1,0 hits on bit 4 only.
        @(negedge clk); rst2 = 1'b1; x2 = 1'b0; #1; check("novl_rst", z2, 1'b0);
        begin
            logic [6:0] s_bits;
            logic [6:0] s_exp;
            s_bits = 7'b0110110;   // bit 6 is sent first
            s_exp  = 7'b0001000;
            for (int i = 6; i >= 0; i--) begin
                @(negedge clk);
                rst2 = 1'b0;
                x2   = s_bits[i];
                #1;
                check($sformatf("novl_bit%0d", 7 - i), z2, s_exp[i]);
            end
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
